// File: rtl/be8_i2c_pkg.sv
// Shared encodings for the be8 I2C master: command opcodes, FSM states and
// the quarter-bit phase index.
package be8_i2c_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    // Index of the last bit of a byte transfer (8 data bits + ACK slot).
    localparam logic [3:0] LAST_BIT = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        STOP,
        ERR,
        DONE
    } state_t;

    typedef logic [1:0] quarter_t;

endpackage

// File: rtl/be8_i2c_phase_timer.sv
// Quarter-bit phase timer. Counts 0..DIV while running and strobes
// phase_done on the last count. In a phase where SCL has been released the
// phase cannot finish until the synchronised SCL reads high, so a slave
// holding SCL low stalls the counter at its final count.
module be8_i2c_phase_timer #(
    parameter int DIV = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic stretch,
    input  logic scl_high,
    output logic phase_done
);

    localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV);

    logic [CW-1:0] cnt_reg;
    logic          at_max;

    assign at_max     = (cnt_reg == CNT_MAX);
    assign phase_done = run && at_max && (!stretch || scl_high);

    // Quarter counter: clears when idle or at phase end, waits at max while stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!run || phase_done) begin
            cnt_reg <= '0;
        end else if (!at_max) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/be8_i2c_master.sv
// Byte-level I2C master engine. Accepts START/WRITE/READ/STOP commands from
// the CPU register bus and sequences the open-drain SCL/SDA pins in
// quarter-bit phases. Pin drives are registered from the next-state values
// so they change exactly at phase boundaries.
module be8_i2c_master
    import be8_i2c_pkg::*;
#(
    parameter int DIV = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_rd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       bus_active,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o
);

    logic [1:0] scl_sync_reg, sda_sync_reg;
    logic       scl_s, sda_s;

    state_t     state_reg, state_next;
    quarter_t   q_reg, q_next;
    logic [3:0] bit_reg, bit_next;
    logic [7:0] sh_reg, sh_next;
    logic       rd_reg, rd_next;
    logic       rd_nack_reg, rd_nack_next;
    logic       ack_reg, ack_next;
    logic       bus_reg, bus_next;
    logic [7:0] rdata_reg, rdata_next;
    logic       nack_reg, nack_next;
    logic       err_reg, err_next;
    logic       scl_reg, scl_next;
    logic       sda_reg, sda_next;
    logic       bit_val;
    logic       accept, run, stretch, phase_done;

    assign scl_s = scl_sync_reg[1];
    assign sda_s = sda_sync_reg[1];

    // DONE is the response cycle; the engine is already free to take a command.
    assign cmd_ready  = (state_reg == IDLE) || (state_reg == DONE);
    assign rsp_valid  = (state_reg == DONE);
    assign rsp_rdata  = rdata_reg;
    assign rsp_nack   = nack_reg;
    assign rsp_err    = err_reg;
    assign bus_active = bus_reg;
    assign scl_o      = scl_reg;
    assign sda_o      = sda_reg;

    assign accept  = cmd_valid && cmd_ready;
    assign run     = (state_reg == START) || (state_reg == BIT) || (state_reg == STOP);
    // Phases that release SCL and therefore must wait out slave stretching.
    assign stretch = ((state_reg == START) && (q_reg == 2'd1)) ||
                     ((state_reg == BIT)   && (q_reg == 2'd2)) ||
                     ((state_reg == STOP)  && (q_reg == 2'd1));

    be8_i2c_phase_timer #(.DIV(DIV)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .stretch   (stretch),
        .scl_high  (scl_s),
        .phase_done(phase_done)
    );

    // Two-flop synchronisers for the raw pin levels (idle bus reads high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], scl_i};
            sda_sync_reg <= {sda_sync_reg[0], sda_i};
        end
    end

    // State, datapath and pin registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            q_reg       <= 2'd0;
            bit_reg     <= 4'd0;
            sh_reg      <= 8'h00;
            rd_reg      <= 1'b0;
            rd_nack_reg <= 1'b0;
            ack_reg     <= 1'b1;
            bus_reg     <= 1'b0;
            rdata_reg   <= 8'h00;
            nack_reg    <= 1'b0;
            err_reg     <= 1'b0;
            scl_reg     <= 1'b1;
            sda_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            q_reg       <= q_next;
            bit_reg     <= bit_next;
            sh_reg      <= sh_next;
            rd_reg      <= rd_next;
            rd_nack_reg <= rd_nack_next;
            ack_reg     <= ack_next;
            bus_reg     <= bus_next;
            rdata_reg   <= rdata_next;
            nack_reg    <= nack_next;
            err_reg     <= err_next;
            scl_reg     <= scl_next;
            sda_reg     <= sda_next;
        end
    end

    // Next-state, datapath and pin-level decode for the upcoming phase.
    always_comb begin
        state_next   = state_reg;
        q_next       = q_reg;
        bit_next     = bit_reg;
        sh_next      = sh_reg;
        rd_next      = rd_reg;
        rd_nack_next = rd_nack_reg;
        ack_next     = ack_reg;
        bus_next     = bus_reg;
        rdata_next   = rdata_reg;
        nack_next    = nack_reg;
        err_next     = err_reg;
        scl_next     = scl_reg;
        sda_next     = sda_reg;
        bit_val      = 1'b1;

        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
                    q_next       = 2'd0;
                    bit_next     = 4'd0;
                    rd_next      = (cmd_op == OP_READ);
                    rd_nack_next = cmd_rd_nack;
                    sh_next      = (cmd_op == OP_WRITE) ? cmd_wdata : 8'h00;
                    if (cmd_op == OP_START) begin
                        state_next = START;
                    end else if (!bus_reg) begin
                        state_next = ERR;
                    end else if (cmd_op == OP_STOP) begin
                        state_next = STOP;
                    end else begin
                        state_next = BIT;
                    end
                end
            end
            START, STOP: begin
                if (phase_done) begin
                    if (q_reg == 2'd3) begin
                        state_next = DONE;
                        bus_next   = (state_reg == START);
                        err_next   = 1'b0;
                    end else begin
                        q_next = q_reg + 2'd1;
                    end
                end
            end
            BIT: begin
                if (phase_done) begin
                    // SDA is sampled as the SCL-high phase q2 ends.
                    if (q_reg == 2'd2) begin
                        if (bit_reg == LAST_BIT) begin
                            ack_next = sda_s;
                        end else if (rd_reg) begin
                            sh_next = {sh_reg[6:0], sda_s};
                        end
                    end
                    if (q_reg == 2'd3) begin
                        if (bit_reg == LAST_BIT) begin
                            state_next = DONE;
                            err_next   = 1'b0;
                            if (rd_reg) begin
                                rdata_next = sh_reg;
                                nack_next  = 1'b0;
                            end else begin
                                nack_next  = ack_reg;
                            end
                        end else begin
                            bit_next = bit_reg + 4'd1;
                            q_next   = 2'd0;
                            if (!rd_reg) begin
                                sh_next = {sh_reg[6:0], 1'b0};
                            end
                        end
                    end else begin
                        q_next = q_reg + 2'd1;
                    end
                end
            end
            ERR: begin
                state_next = DONE;
                err_next   = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // Level the master puts on SDA during the upcoming bit.
        if (bit_next == LAST_BIT) begin
            bit_val = rd_next ? rd_nack_next : 1'b1;
        end else begin
            bit_val = rd_next ? 1'b1 : sh_next[7];
        end

        case (state_next)
            START: begin
                case (q_next)
                    2'd0:    sda_next = 1'b1;
                    2'd1:    begin scl_next = 1'b1; sda_next = 1'b1; end
                    2'd2:    begin scl_next = 1'b1; sda_next = 1'b0; end
                    default: begin scl_next = 1'b0; sda_next = 1'b0; end
                endcase
            end
            BIT: begin
                scl_next = q_next[1];
                sda_next = bit_val;
            end
            STOP: begin
                case (q_next)
                    2'd0:    begin scl_next = 1'b0; sda_next = 1'b0; end
                    2'd1:    begin scl_next = 1'b1; sda_next = 1'b0; end
                    default: begin scl_next = 1'b1; sda_next = 1'b1; end
                endcase
            end
            DONE: begin
                // A finished byte parks the bus with SCL held low.
                if (state_reg == BIT) begin
                    scl_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_be8_i2c_master.sv
// Testbench for be8_i2c_master: open-drain bus with a small slave model,
// a response scoreboard and a pin monitor for START/STOP and bit capture.
module tb_be8_i2c_master;
    import be8_i2c_pkg::*;

    localparam int DIV    = 3;
    localparam int Q      = DIV + 1;
    localparam int LAT_SC = 4 * Q + 1;
    localparam int LAT_WR = 36 * Q + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_rd_nack = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, bus_active;
    logic [7:0] rsp_rdata;
    logic       scl_o, sda_o;

    logic       slave_scl = 1'b1;
    logic       slave_sda;
    wire        scl_w = scl_o & slave_scl;
    wire        sda_w = sda_o & slave_sda;

    be8_i2c_master #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_wdata  (cmd_wdata),
        .cmd_rd_nack(cmd_rd_nack),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_nack   (rsp_nack),
        .rsp_err    (rsp_err),
        .bus_active (bus_active),
        .scl_i      (scl_w),
        .sda_i      (sda_w),
        .scl_o      (scl_o),
        .sda_o      (sda_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int         rise_cnt = 0;
    int         fall_idx = 0;
    int         rise_base = 0;
    int         rel;
    int         slave_mode = 0;   // 0 released, 1 ACK a written byte, 2 send slave_byte
    logic [7:0] slave_byte = 8'h00;

    assign rel = fall_idx - rise_base;

    always @(posedge scl_w) rise_cnt = rise_cnt + 1;
    always @(negedge scl_w) fall_idx = rise_cnt;

    // Slave SDA only changes after SCL falls (fall_idx moves on falling edges).
    always @* begin
        slave_sda = 1'b1;
        if (slave_mode == 1 && rel == 8) slave_sda = 1'b0;
        if (slave_mode == 2 && rel >= 0 && rel < 8) slave_sda = slave_byte[3'(7 - rel)];
    end

    // ---------------- pin monitor ----------------
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    int   start_cnt = 0, stop_cnt = 0, act_cnt = 0;
    logic log_w[$];
    logic log_m[$];

    always @(negedge clk) begin
        if (prev_scl && scl_w && prev_sda && !sda_w) start_cnt++;
        if (prev_scl && scl_w && !prev_sda && sda_w) stop_cnt++;
        if (!prev_scl && scl_w) begin
            log_w.push_back(sda_w);
            log_m.push_back(sda_o);
        end
        if (!scl_o || !sda_o) act_cnt++;
        prev_scl = scl_w;
        prev_sda = sda_w;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string      tag;
        logic       err;
        logic       chk_nack;
        logic       nack;
        logic [7:0] rdata;
        logic       bus;
        int         lat_min;
        int         lat_max;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   lat;
    logic [7:0] exp_rdata = 8'h00;
    logic       exp_nack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - acc_cyc;
                    check({e.tag, "_err"}, rsp_err, e.err);
                    if (e.chk_nack) check({e.tag, "_nack"}, rsp_nack, e.nack);
                    check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                    check({e.tag, "_bus"}, bus_active, e.bus);
                    check({e.tag, "_lat_in_range"}, (lat >= e.lat_min && lat <= e.lat_max), 32'd1);
                    $display("rsp %s lat=%0d err=%b nack=%b rdata=%02h bus=%b",
                             e.tag, lat, rsp_err, rsp_nack, rsp_rdata, bus_active);
                end
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
        end
    end

    function automatic exp_t mk(input string tag, input logic err, input logic chk_nack,
                                input logic nack, input logic [7:0] rd, input logic bus,
                                input int lmin, input int lmax);
        exp_t x;
        x.tag = tag; x.err = err; x.chk_nack = chk_nack; x.nack = nack;
        x.rdata = rd; x.bus = bus; x.lat_min = lmin; x.lat_max = lmax;
        return x;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [7:0] wd, input logic nk, input exp_t x);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        while (!cmd_ready && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!cmd_ready) check({x.tag, "_ready_timeout"}, 32'd0, 32'd1);
        sb.push_back(x);
        rise_base   = rise_cnt;
        cmd_op      = op;
        cmd_wdata   = wd;
        cmd_rd_nack = nk;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] wd, input logic nk, input exp_t x);
        issue(op, wd, nk, x);
        wait_done(x.tag);
    endtask

    task automatic wait_rel_low(input int target, input string tag);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (rel == target && !scl_w) break;
        end
        if (i == 2000) check({tag, "_bit_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_byte(input string tag, input logic [7:0] exp_b, input logic exp_ninth);
        logic [7:0] b;
        b = 8'h00;
        check({tag, "_edges"}, log_w.size(), 32'd9);
        if (log_w.size() >= 9) begin
            for (int i = 0; i < 8; i++) b = {b[6:0], log_w[i]};
            check({tag, "_byte"}, b, exp_b);
            check({tag, "_ninth"}, log_w[8], exp_ninth);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        slave_mode = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_scl_o", scl_o, 1'b1);
        check("rst_sda_o", sda_o, 1'b1);
        check("rst_bus_active", bus_active, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_nack", rsp_nack, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // START then WRITE 0xA0 with an ACKing slave
        run_cmd(OP_START, 8'h00, 1'b0, mk("start0", 1'b0, 1'b0, 1'b0, exp_rdata, 1'b1, LAT_SC, LAT_SC));
        check("start0_sda_fall_scl_high", start_cnt, 32'd1);
        log_w.delete(); log_m.delete();
        slave_mode = 1;
        run_cmd(OP_WRITE, 8'hA0, 1'b0, mk("wr_a0", 1'b0, 1'b1, 1'b0, exp_rdata, 1'b1, LAT_WR, LAT_WR));
        check_byte("wr_a0", 8'hA0, 1'b0);
        check("wr_a0_no_extra_start", start_cnt, 32'd1);
        check("wr_a0_no_stop", stop_cnt, 32'd0);

        // WRITE 0x3C with no slave: NACK, bus stays active
        slave_mode = 0;
        run_cmd(OP_WRITE, 8'h3C, 1'b0, mk("wr_3c", 1'b0, 1'b1, 1'b1, exp_rdata, 1'b1, LAT_WR, LAT_WR));

        // READ 0x5A with master NACK, then STOP
        slave_byte = 8'h5A;
        slave_mode = 2;
        log_w.delete(); log_m.delete();
        run_cmd(OP_READ, 8'h00, 1'b1, mk("rd_5a", 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, LAT_WR, LAT_WR));
        exp_rdata = 8'h5A;
        exp_nack  = 1'b0;
        check_byte("rd_5a", 8'h5A, 1'b1);
        if (log_m.size() >= 9) check("rd_5a_master_ninth_released", log_m[8], 1'b1);
        else check("rd_5a_master_ninth_present", log_m.size(), 32'd9);
        slave_mode = 0;
        run_cmd(OP_STOP, 8'h00, 1'b0, mk("stop0", 1'b0, 1'b0, 1'b0, exp_rdata, 1'b0, LAT_SC, LAT_SC));
        check("stop0_sda_rise_scl_high", stop_cnt, 32'd1);

        // READ with the bus idle: error, no pin activity
        act_cnt = 0;
        run_cmd(OP_READ, 8'h00, 1'b0, mk("rd_err", 1'b1, 1'b1, exp_nack, exp_rdata, 1'b0, 2, 2));
        check("rd_err_pins_idle", act_cnt, 32'd0);

        // Clock stretching during bit 3 of a WRITE
        run_cmd(OP_START, 8'h00, 1'b0, mk("start1", 1'b0, 1'b0, 1'b0, exp_rdata, 1'b1, LAT_SC, LAT_SC));
        log_w.delete(); log_m.delete();
        slave_mode = 1;
        issue(OP_WRITE, 8'hC5, 1'b0, mk("wr_str", 1'b0, 1'b1, 1'b0, exp_rdata, 1'b1, LAT_WR + 40, LAT_WR + 60));
        wait_rel_low(3, "wr_str");
        slave_scl = 1'b0;
        repeat (2 * Q + 50) @(posedge clk);
        #1 slave_scl = 1'b1;
        wait_done("wr_str");
        check_byte("wr_str", 8'hC5, 1'b0);
        slave_mode = 0;
        run_cmd(OP_STOP, 8'h00, 1'b0, mk("stop1", 1'b0, 1'b0, 1'b0, exp_rdata, 1'b0, LAT_SC, LAT_SC));

        // Asynchronous reset in bit 5 of a WRITE
        run_cmd(OP_START, 8'h00, 1'b0, mk("start2", 1'b0, 1'b0, 1'b0, exp_rdata, 1'b1, LAT_SC, LAT_SC));
        slave_mode = 1;
        issue(OP_WRITE, 8'hA0, 1'b0, mk("wr_rst", 1'b0, 1'b1, 1'b0, exp_rdata, 1'b1, LAT_WR, LAT_WR));
        wait_rel_low(5, "wr_rst");
        #2;
        check("wr_rst_pre_scl_low", scl_o, 1'b0);
        check("wr_rst_pre_sda_low", sda_o, 1'b0);
        rst_n = 1'b0;
        #1;
        check("wr_rst_scl_released", scl_o, 1'b1);
        check("wr_rst_sda_released", sda_o, 1'b1);
        check("wr_rst_bus_active", bus_active, 1'b0);
        sb.delete();
        slave_mode = 0;
        exp_rdata  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("wr_rst_cmd_ready", cmd_ready, 1'b1);
        check("wr_rst_rsp_valid", rsp_valid, 1'b0);
        check("wr_rst_rdata_cleared", rsp_rdata, 8'h00);

        // Engine usable after reset
        run_cmd(OP_START, 8'h00, 1'b0, mk("start3", 1'b0, 1'b0, 1'b0, exp_rdata, 1'b1, LAT_SC, LAT_SC));
        run_cmd(OP_STOP, 8'h00, 1'b0, mk("stop3", 1'b0, 1'b0, 1'b0, exp_rdata, 1'b0, LAT_SC, LAT_SC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
